// File: rtl/fetch_2_line_aligner.sv
// Fetch stage 2: even/odd line latches and byte-aligned decode window.
// Two 16-byte latches hold the even and odd I$ lines of a 32-byte pair.
// A 5-bit byte pointer selects which bank is "first"; the window is the
// 16 bytes starting at the pointer, spilling into the other bank. Decode
// consumption advances the pointer; crossing out of the first bank
// releases it so fetch stage 1 can refill it with the line two ahead.
module fetch_2_line_aligner #(
    parameter int LINE_W = 128,
    parameter int OFF_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LINE_W-1:0] even_line_in,
    input  logic [LINE_W-1:0] odd_line_in,
    input  logic              cache_miss_even,
    input  logic              cache_miss_odd,
    input  logic              flush,
    input  logic [OFF_W-1:0]  flush_offset,
    input  logic              dec_ld,
    input  logic [OFF_W-1:0]  dec_len,
    output logic              even_latch_was_loaded,
    output logic              odd_latch_was_loaded,
    output logic              win_valid,
    output logic [LINE_W-1:0] win_bytes,
    output logic [OFF_W-1:0]  win_ptr
);

    localparam int BYTE_W = 8;
    localparam int BYTES  = LINE_W / BYTE_W;
    localparam int IDX_W  = OFF_W - 1;
    localparam logic [OFF_W-1:0] MAX_LEN = OFF_W'(BYTES);

    // Clamp a decode length to one line; zero stays zero (treated as no-op).
    function automatic logic [OFF_W-1:0] sat_len(input logic [OFF_W-1:0] len);
        if (len > MAX_LEN) begin
            return MAX_LEN;
        end else begin
            return len;
        end
    endfunction

    // True when consuming len bytes from byte offset off within the first
    // bank runs past its end, i.e. the first bank is fully used up.
    function automatic logic crosses_bank(input logic [IDX_W-1:0] off,
                                          input logic [OFF_W-1:0] len);
        return (({1'b0, off} + len) >= MAX_LEN);
    endfunction

    // Architectural state
    logic [OFF_W-1:0]  ptr_q,        ptr_d;
    logic [LINE_W-1:0] even_line_q,  even_line_d;
    logic [LINE_W-1:0] odd_line_q,   odd_line_d;
    logic              even_vld_q,   even_vld_d;
    logic              odd_vld_q,    odd_vld_d;

    // Combinational helpers
    logic              odd_first_s;
    logic              first_vld_s;
    logic              second_vld_s;
    logic [LINE_W-1:0] first_line_s;
    logic [LINE_W-1:0] second_line_s;
    logic              aligned_s;
    logic              win_valid_s;
    logic [LINE_W-1:0] win_bytes_s;
    logic [OFF_W-1:0]  len_s;
    logic              fire_s;
    logic              rel_first_s;
    logic              rel_even_s;
    logic              rel_odd_s;
    logic              load_even_s;
    logic              load_odd_s;

    // Bank ordering: the pointer's top bit names the bank holding byte 0.
    always_comb begin
        odd_first_s = ptr_q[OFF_W-1];
        if (odd_first_s) begin
            first_vld_s   = odd_vld_q;
            second_vld_s  = even_vld_q;
            first_line_s  = odd_line_q;
            second_line_s = even_line_q;
        end else begin
            first_vld_s   = even_vld_q;
            second_vld_s  = odd_vld_q;
            first_line_s  = even_line_q;
            second_line_s = odd_line_q;
        end
    end

    // Byte rotator: window byte k comes from position ptr[3:0]+k of {second,first}.
    always_comb begin
        logic [OFF_W-1:0] pos;
        pos         = '0;
        win_bytes_s = '0;
        for (int k = 0; k < BYTES; k++) begin
            pos = {1'b0, ptr_q[IDX_W-1:0]} + OFF_W'(k);
            if (pos[IDX_W]) begin
                win_bytes_s[BYTE_W*k +: BYTE_W] = second_line_s[BYTE_W*pos[IDX_W-1:0] +: BYTE_W];
            end else begin
                win_bytes_s[BYTE_W*k +: BYTE_W] = first_line_s[BYTE_W*pos[IDX_W-1:0] +: BYTE_W];
            end
        end
    end

    // Window validity: an aligned pointer needs only the first bank.
    always_comb begin
        aligned_s   = (ptr_q[IDX_W-1:0] == {IDX_W{1'b0}});
        win_valid_s = first_vld_s & (aligned_s | second_vld_s);
    end

    // Consumption and bank release; a flush cycle ignores decode entirely.
    always_comb begin
        len_s       = sat_len(dec_len);
        fire_s      = dec_ld & win_valid_s & ~flush & (len_s != {OFF_W{1'b0}});
        rel_first_s = fire_s & crosses_bank(ptr_q[IDX_W-1:0], len_s);
        rel_even_s  = rel_first_s & ~odd_first_s;
        rel_odd_s   = rel_first_s &  odd_first_s;
    end

    // Latch load requests, reported straight back to fetch stage 1.
    always_comb begin
        load_even_s = (~even_vld_q | rel_even_s | flush) & ~cache_miss_even & ~reset;
        load_odd_s  = (~odd_vld_q  | rel_odd_s  | flush) & ~cache_miss_odd  & ~reset;
    end

    // Next-state: pointer update, then per-bank load/release/flush of the latches.
    always_comb begin
        ptr_d       = ptr_q;
        even_line_d = even_line_q;
        odd_line_d  = odd_line_q;
        even_vld_d  = even_vld_q;
        odd_vld_d   = odd_vld_q;

        if (flush) begin
            ptr_d = flush_offset;
        end else if (fire_s) begin
            ptr_d = ptr_q + len_s;
        end else begin
            ptr_d = ptr_q;
        end

        // A load wins over a same-cycle release or flush clear.
        if (load_even_s) begin
            even_line_d = even_line_in;
            even_vld_d  = 1'b1;
        end else if (flush | rel_even_s) begin
            even_vld_d  = 1'b0;
        end else begin
            even_vld_d  = even_vld_q;
        end

        if (load_odd_s) begin
            odd_line_d = odd_line_in;
            odd_vld_d  = 1'b1;
        end else if (flush | rel_odd_s) begin
            odd_vld_d  = 1'b0;
        end else begin
            odd_vld_d  = odd_vld_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q       <= {OFF_W{1'b0}};
            even_line_q <= {LINE_W{1'b0}};
            odd_line_q  <= {LINE_W{1'b0}};
            even_vld_q  <= 1'b0;
            odd_vld_q   <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            even_line_q <= even_line_d;
            odd_line_q  <= odd_line_d;
            even_vld_q  <= even_vld_d;
            odd_vld_q   <= odd_vld_d;
        end
    end

    // Output drive; the window and load strobes are zero-latency from state.
    always_comb begin
        even_latch_was_loaded = load_even_s;
        odd_latch_was_loaded  = load_odd_s;
        win_valid             = win_valid_s;
        win_bytes             = win_bytes_s;
        win_ptr               = ptr_q;
    end

endmodule

// File: tb/tb_fetch_2_line_aligner.sv
// Bench for fetch_2_line_aligner: directed scenarios, a byte-array model
// of the 32-byte line pair compared every cycle, plus literal spot checks.
module tb_fetch_2_line_aligner;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] even_line_in = '0;
    logic [127:0] odd_line_in = '0;
    logic         cache_miss_even = 1'b1;
    logic         cache_miss_odd = 1'b1;
    logic         flush = 1'b0;
    logic [4:0]   flush_offset = '0;
    logic         dec_ld = 1'b0;
    logic [4:0]   dec_len = '0;
    logic         even_latch_was_loaded;
    logic         odd_latch_was_loaded;
    logic         win_valid;
    logic [127:0] win_bytes;
    logic [4:0]   win_ptr;

    int errors = 0;
    int checks = 0;

    fetch_2_line_aligner dut (
        .clk                   (clk),
        .reset                 (reset),
        .even_line_in          (even_line_in),
        .odd_line_in           (odd_line_in),
        .cache_miss_even       (cache_miss_even),
        .cache_miss_odd        (cache_miss_odd),
        .flush                 (flush),
        .flush_offset          (flush_offset),
        .dec_ld                (dec_ld),
        .dec_len               (dec_len),
        .even_latch_was_loaded (even_latch_was_loaded),
        .odd_latch_was_loaded  (odd_latch_was_loaded),
        .win_valid             (win_valid),
        .win_bytes             (win_bytes),
        .win_ptr               (win_ptr)
    );

    always #5 clk = ~clk;

    // ---------------- model: the pair as 32 bytes plus two valid bits ----------------
    int         m_ptr = 0;
    bit         m_ve = 1'b0;
    bit         m_vo = 1'b0;
    logic [7:0] m_e [16];
    logic [7:0] m_o [16];

    function automatic bit exp_valid();
        for (int k = 0; k < 16; k++) begin
            int idx = (m_ptr + k) % 32;
            if (idx < 16 && !m_ve) return 1'b0;
            if (idx >= 16 && !m_vo) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [127:0] exp_win();
        logic [127:0] w = '0;
        for (int k = 0; k < 16; k++) begin
            int idx = (m_ptr + k) % 32;
            w[8*k +: 8] = (idx < 16) ? m_e[idx] : m_o[idx - 16];
        end
        return w;
    endfunction

    function automatic int eff_len();
        int l = int'(dec_len);
        return (l > 16) ? 16 : l;
    endfunction

    // Decode used up every remaining byte of the bank the pointer sits in.
    function automatic bit rel_first();
        return dec_ld && !flush && exp_valid() && eff_len() > 0 &&
               ((m_ptr % 16) + eff_len() >= 16);
    endfunction

    function automatic bit ld_even();
        return !reset && !cache_miss_even &&
               (!m_ve || flush || (rel_first() && m_ptr < 16));
    endfunction

    function automatic bit ld_odd();
        return !reset && !cache_miss_odd &&
               (!m_vo || flush || (rel_first() && m_ptr >= 16));
    endfunction

    // Model state advance at each clock edge (async clear on reset).
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ptr <= 0;
            m_ve  <= 1'b0;
            m_vo  <= 1'b0;
            for (int k = 0; k < 16; k++) begin
                m_e[k] <= 8'h00;
                m_o[k] <= 8'h00;
            end
        end else begin
            if (flush)
                m_ptr <= int'(flush_offset);
            else if (dec_ld && exp_valid())
                m_ptr <= (m_ptr + eff_len()) % 32;
            m_ve <= ld_even() ? 1'b1 : ((flush || (rel_first() && m_ptr < 16)) ? 1'b0 : m_ve);
            m_vo <= ld_odd()  ? 1'b1 : ((flush || (rel_first() && m_ptr >= 16)) ? 1'b0 : m_vo);
            for (int k = 0; k < 16; k++) begin
                if (ld_even()) m_e[k] <= even_line_in[8*k +: 8];
                if (ld_odd())  m_o[k] <= odd_line_in[8*k +: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("model win_valid", 128'(win_valid), 128'(exp_valid()));
        chk("model win_ptr", 128'(win_ptr), 128'(m_ptr[4:0]));
        chk("model win_bytes", win_bytes, exp_win());
        chk("model even_loaded", 128'(even_latch_was_loaded), 128'(ld_even()));
        chk("model odd_loaded", 128'(odd_latch_was_loaded), 128'(ld_odd()));
    end

    // Line whose byte k is {tag, k}.
    function automatic logic [127:0] mk_line(input logic [3:0] tag);
        logic [127:0] l;
        for (int k = 0; k < 16; k++) l[8*k +: 8] = {tag, 4'(k)};
        return l;
    endfunction

    task automatic apply(input logic fl, input logic [4:0] off, input logic ld,
                         input logic [4:0] len, input logic me, input logic mo,
                         input logic [3:0] etag, input logic [3:0] otag);
        flush           = fl;
        flush_offset    = off;
        dec_ld          = ld;
        dec_len         = len;
        cache_miss_even = me;
        cache_miss_odd  = mo;
        even_line_in    = mk_line(etag);
        odd_line_in     = mk_line(otag);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        apply(1'b0, 5'h00, 1'b0, 5'd0, 1'b1, 1'b1, 4'h0, 4'h0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("reset win_valid", 128'(win_valid), 128'd0);
        chk("reset win_ptr", 128'(win_ptr), 128'd0);
        chk("reset win_bytes", win_bytes, 128'd0);

        // Cold start at offset 4
        apply(1'b1, 5'h04, 1'b0, 5'd0, 1'b0, 1'b0, 4'hA, 4'hB);
        chk("cold even_loaded", 128'(even_latch_was_loaded), 128'd1);
        chk("cold odd_loaded", 128'(odd_latch_was_loaded), 128'd1);
        tick();
        apply(1'b0, 5'h00, 1'b0, 5'd0, 1'b0, 1'b0, 4'hC, 4'hD);
        chk("cold win_valid", 128'(win_valid), 128'd1);
        chk("cold byte0", 128'(win_bytes[7:0]), 128'(8'hA4));
        chk("cold byte12", 128'(win_bytes[103:96]), 128'(8'hB0));
        chk("cold held no load", 128'(even_latch_was_loaded), 128'd0);
        tick();

        // Line crossing from 0x0C by 6
        apply(1'b0, 5'h00, 1'b1, 5'd8, 1'b0, 1'b0, 4'hC, 4'hD);
        tick();
        apply(1'b0, 5'h00, 1'b1, 5'd6, 1'b0, 1'b0, 4'hC, 4'hD);
        chk("cross start ptr", 128'(win_ptr), 128'(5'h0C));
        chk("cross even_loaded", 128'(even_latch_was_loaded), 128'd1);
        chk("cross odd_loaded", 128'(odd_latch_was_loaded), 128'd0);
        tick();
        apply(1'b0, 5'h00, 1'b0, 5'd0, 1'b0, 1'b0, 4'hC, 4'hD);
        chk("cross ptr", 128'(win_ptr), 128'(5'h12));
        chk("cross byte0", 128'(win_bytes[7:0]), 128'(8'hB2));
        chk("cross byte14", 128'(win_bytes[119:112]), 128'(8'hC0));
        apply(1'b0, 5'h00, 1'b1, 5'd6, 1'b0, 1'b0, 4'hC, 4'hD);
        tick();

        // Miss stall at 0x18 with the even latch empty
        apply(1'b1, 5'h18, 1'b0, 5'd0, 1'b1, 1'b0, 4'hF, 4'hE);
        chk("stall flush even_loaded", 128'(even_latch_was_loaded), 128'd0);
        chk("stall flush odd_loaded", 128'(odd_latch_was_loaded), 128'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 5'h00, 1'b1, 5'd4, 1'b1, 1'b0, 4'hF, 4'hE);
            chk("stall win_valid", 128'(win_valid), 128'd0);
            chk("stall even_loaded", 128'(even_latch_was_loaded), 128'd0);
            chk("stall ptr", 128'(win_ptr), 128'(5'h18));
            tick();
        end
        apply(1'b0, 5'h00, 1'b0, 5'd0, 1'b0, 1'b0, 4'hF, 4'hE);
        chk("stall hit even_loaded", 128'(even_latch_was_loaded), 128'd1);
        tick();
        apply(1'b0, 5'h00, 1'b0, 5'd0, 1'b0, 1'b0, 4'hF, 4'hE);
        chk("stall win_valid after", 128'(win_valid), 128'd1);
        chk("stall byte0", 128'(win_bytes[7:0]), 128'(8'hE8));
        chk("stall byte8", 128'(win_bytes[71:64]), 128'(8'hF0));

        // Flush beats consume, target 0x1F
        apply(1'b1, 5'h1F, 1'b1, 5'd3, 1'b0, 1'b0, 4'h1, 4'h2);
        tick();
        apply(1'b0, 5'h00, 1'b0, 5'd0, 1'b0, 1'b0, 4'h1, 4'h2);
        chk("flush ptr", 128'(win_ptr), 128'(5'h1F));
        chk("flush byte0", 128'(win_bytes[7:0]), 128'(8'h2F));
        chk("flush byte1", 128'(win_bytes[15:8]), 128'(8'h10));

        // 31 + 2 wraps to 1 and releases the odd bank
        apply(1'b0, 5'h00, 1'b1, 5'd2, 1'b0, 1'b0, 4'h4, 4'h3);
        chk("wrap odd_loaded", 128'(odd_latch_was_loaded), 128'd1);
        chk("wrap even_loaded", 128'(even_latch_was_loaded), 128'd0);
        tick();
        apply(1'b0, 5'h00, 1'b0, 5'd0, 1'b0, 1'b0, 4'h4, 4'h3);
        chk("wrap ptr", 128'(win_ptr), 128'(5'h01));
        chk("wrap byte0", 128'(win_bytes[7:0]), 128'(8'h11));
        chk("wrap byte15", 128'(win_bytes[127:120]), 128'(8'h30));

        // 0x1E + 16 -> 0x0E, odd released (odd refill held off by a miss)
        apply(1'b1, 5'h1E, 1'b0, 5'd0, 1'b0, 1'b0, 4'h5, 4'h6);
        tick();
        apply(1'b0, 5'h00, 1'b1, 5'd16, 1'b0, 1'b1, 4'h7, 4'h8);
        chk("len16 even_loaded", 128'(even_latch_was_loaded), 128'd0);
        chk("len16 odd_loaded", 128'(odd_latch_was_loaded), 128'd0);
        tick();
        apply(1'b0, 5'h00, 1'b0, 5'd0, 1'b0, 1'b1, 4'h7, 4'h8);
        chk("len16 ptr", 128'(win_ptr), 128'(5'h0E));
        chk("len16 win_valid", 128'(win_valid), 128'd0);

        // Same again with dec_len 20, which saturates to 16
        apply(1'b1, 5'h1E, 1'b0, 5'd0, 1'b0, 1'b0, 4'h5, 4'h6);
        tick();
        apply(1'b0, 5'h00, 1'b1, 5'd20, 1'b0, 1'b1, 4'h7, 4'h8);
        tick();
        apply(1'b0, 5'h00, 1'b0, 5'd0, 1'b0, 1'b1, 4'h7, 4'h8);
        chk("len20 ptr", 128'(win_ptr), 128'(5'h0E));
        chk("len20 win_valid", 128'(win_valid), 128'd0);
        apply(1'b0, 5'h00, 1'b0, 5'd0, 1'b0, 1'b0, 4'h7, 4'h8);
        chk("len20 odd refill", 128'(odd_latch_was_loaded), 128'd1);
        tick();
        apply(1'b0, 5'h00, 1'b0, 5'd0, 1'b0, 1'b0, 4'h7, 4'h8);
        chk("len20 byte0", 128'(win_bytes[7:0]), 128'(8'h5E));
        chk("len20 byte2", 128'(win_bytes[23:16]), 128'(8'h80));

        // dec_len 0 is a no-op; then reset mid-operation at ptr 9
        apply(1'b1, 5'h09, 1'b0, 5'd0, 1'b0, 1'b0, 4'h9, 4'hA);
        tick();
        apply(1'b0, 5'h00, 1'b1, 5'd0, 1'b0, 1'b0, 4'h9, 4'hA);
        tick();
        apply(1'b0, 5'h00, 1'b0, 5'd0, 1'b0, 1'b0, 4'h9, 4'hA);
        chk("len0 ptr", 128'(win_ptr), 128'(5'h09));
        chk("len0 win_valid", 128'(win_valid), 128'd1);
        reset = 1'b1;
        #1;
        chk("midreset win_valid", 128'(win_valid), 128'd0);
        chk("midreset win_ptr", 128'(win_ptr), 128'd0);
        chk("midreset even_loaded", 128'(even_latch_was_loaded), 128'd0);
        chk("midreset odd_loaded", 128'(odd_latch_was_loaded), 128'd0);
        chk("midreset win_bytes", win_bytes, 128'd0);
        tick();
        reset = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
